aurora_stream_ctrl: RTL and testbench
=====================================

Name: aurora_stream_ctrl

Overview:
Parametrised stream controller between the Aurora 8b10b user interface and its TX sources.
- Measures RX frames: words per frame, with a ready flag, plus a frame count.
- Emits a one-cycle pulse per received frame end.
- Arbitrates the Aurora TX port between a user source, the loopback FIFO and an internal programmable frame generator.
- Switches TX source only on frame boundaries; replaces the fixed two-word stimulus and the hard-wired loopback mux.

Parameters:
DATA_WIDTH, 32, width of all tdata buses
CNT_WIDTH, 16, width of word/frame counters
LEN_WIDTH, 8, width of generator frame length (words)
PERIOD_WIDTH, 16, width of generator inter-frame gap (cycles)

Ports:
m_axis_aclk  in  1  single clock (Aurora user_clk_out)
m_axis_aresetn  in  1  asynchronous active-low reset
rx_tvalid  in  1  Aurora RX valid (no backpressure)
rx_tdata  in  DATA_WIDTH  Aurora RX data (monitored only)
rx_tlast  in  1  Aurora RX end of frame
lb_tvalid / lb_tdata / lb_tlast  in  1/DATA_WIDTH/1  loopback FIFO master
lb_tready  out  1  ready to loopback FIFO
usr_tvalid / usr_tdata / usr_tlast  in  1/DATA_WIDTH/1  user source
usr_tready  out  1  ready to user source
tx_tvalid / tx_tdata / tx_tlast  out  1/DATA_WIDTH/1  to Aurora TX
tx_tready  in  1  Aurora TX ready
ctrl_mode  in  2  00 user, 01 loopback, 10 generator, 11 off
ctrl_gen_len  in  LEN_WIDTH  generator words per frame; 0 means generator disabled
ctrl_gen_period  in  PERIOD_WIDTH  idle cycles between generated frames
ctrl_gen_base  in  DATA_WIDTH  first generated data word
stat_rx_words  out  CNT_WIDTH  words in current/last RX frame
stat_rx_words_rdy  out  1  stat_rx_words holds the complete last-frame count
stat_rx_frames  out  CNT_WIDTH  RX frames since reset
stat_tx_frames  out  CNT_WIDTH  TX frames completed since reset
rx_last_pulse  out  1  one-cycle pulse after each RX tlast beat

Behaviour:
- Reset: all outputs 0, including tx_tvalid, readies and counters; active source = off; generator in IDLE with gap counter 0.
- RX stats, counting rx_tvalid beats only:
  - First beat after a tlast (or after reset) loads the word count to 1; later beats increment it.
  - A tlast beat registers rdy=1 and increments stat_rx_frames.
  - stat_rx_words_rdy is rdy & ~rx_tvalid, so it drops combinationally when the next frame starts.
  - All counters saturate at all-ones; they never wrap.
- rx_last_pulse: registered; high exactly one cycle after a cycle with rx_tvalid & rx_tlast.
- Source select:
  - Active source register loads ctrl_mode only while no TX frame is open.
  - A frame opens on the first accepted beat (tx_tvalid & tx_tready) and closes on the tlast handshake.
  - A mid-frame ctrl_mode change takes effect the cycle after the closing handshake.
- Mux:
  - tx_* routes from the active source; the selected source's tready = tx_tready, and every other tready = 0.
  - Mode off: tx_tvalid=0 and all readies 0.
  - The mux is purely combinational, adding zero latency.
- Generator FSM:
  - IDLE: if active=generator and ctrl_gen_len≠0, latch len, base and period, then go to SEND.
  - SEND: present word base+i with tvalid=1 and hold it stable while tready=0. On the handshake, i increments. tlast=1 when i=len-1. After the last handshake go to GAP.
  - GAP: count latched-period cycles, then return to IDLE. With period=0, GAP lasts 1 cycle.
- Data arithmetic: base+i is modulo 2^DATA_WIDTH.
- ctrl_gen_* changes during SEND/GAP apply only to the next frame.
- stat_tx_frames increments on every tx tlast handshake, whatever the source.
- Reset mid-frame: asynchronous clear; the open frame is abandoned with no tlast emitted.

Decomposition:
- Shared package aurora_pkg: mode encodings (MODE_USER, MODE_LOOP, MODE_GEN, MODE_OFF) and generator state encodings.
- One natural sub-module: axis_frame_gen (the generator FSM plus its data/last logic).
- RX stats, the source-select register and the mux stay in the parent.

Test Plan:
- RX frame of 5 beats with tlast on beat 5, rx_tvalid gapped → stat_rx_words=5, rdy=1 once rx_tvalid is low, stat_rx_frames=1, rx_last_pulse high one cycle after beat 5.
- Generator len=2, base=5, period=255, tready=1 → frames {5,6} repeat with exactly 256 idle cycles between tlast and the next tvalid; stat_tx_frames counts them.
- Generator len=3, tready toggled 0/1 each cycle → each word stays stable until its handshake; sequence base, base+1, base+2 with tlast only on the third.
- Mode switch loopback→user while a 4-word loopback frame is on beat 2 → the loopback frame completes; usr_tready stays 0 until the cycle after the lb tlast handshake.
- Generator base=0xFFFFFFFF, len=2 → data 0xFFFFFFFF then 0x00000000; with CNT_WIDTH=4, 20 RX frames leave stat_rx_frames=15.
- aresetn asserted mid SEND → tx_tvalid=0 immediately (asynchronous), counters 0; after release in generator mode the next frame restarts at base.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared encodings for the Aurora stream controller and its frame generator.
package aurora_pkg;

   // TX source selection, matches the ctrl_mode input encoding
   typedef enum logic [1:0] {
      MODE_USER = 2'b00,
      MODE_LOOP = 2'b01,
      MODE_GEN  = 2'b10,
      MODE_OFF  = 2'b11
   } mode_e;

   // Frame generator states
   typedef enum logic [1:0] {
      GEN_IDLE = 2'b00,
      GEN_SEND = 2'b01,
      GEN_GAP  = 2'b10
   } gen_state_e;

endpackage

// File: rtl/axis_frame_gen.sv
// Programmable AXI-Stream frame generator: frames of len words counting up
// from base, separated by a programmable idle gap.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// GEN_IDLE | waiting for enable with a non-zero length; latches len/base/period
// GEN_SEND | presenting base+i, held stable until the handshake
// GEN_GAP  | idle for max(period,1) cycles after the last word
module axis_frame_gen
   import aurora_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int LEN_WIDTH    = 8,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_en,
   input  logic [LEN_WIDTH-1:0]    i_len,
   input  logic [PERIOD_WIDTH-1:0] i_period,
   input  logic [DATA_WIDTH-1:0]   i_base,
   input  logic                    i_tready,
   output logic                    o_tvalid,
   output logic [DATA_WIDTH-1:0]   o_tdata,
   output logic                    o_tlast
);

   gen_state_e              r_state;
   logic                    r_valid;
   logic                    r_last;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [LEN_WIDTH-1:0]    r_len;
   logic [LEN_WIDTH-1:0]    r_idx;
   logic [PERIOD_WIDTH-1:0] r_period;
   logic [PERIOD_WIDTH-1:0] r_gap;
   logic [LEN_WIDTH-1:0]    w_idx_nxt;

   assign w_idx_nxt = r_idx + LEN_WIDTH'(1);

   // Generator FSM; data and last are precomputed so outputs come straight from flops
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= GEN_IDLE;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_data   <= '0;
         r_len    <= '0;
         r_idx    <= '0;
         r_period <= '0;
         r_gap    <= '0;
      end else begin
         case (r_state)
            GEN_IDLE: begin
               if (i_en && (i_len != '0)) begin
                  r_len    <= i_len;
                  r_period <= i_period;
                  r_data   <= i_base;
                  r_idx    <= '0;
                  r_last   <= (i_len == LEN_WIDTH'(1));
                  r_valid  <= 1'b1;
                  r_state  <= GEN_SEND;
               end
            end
            GEN_SEND: begin
               if (i_tready) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_gap   <= r_period;
                     r_state <= GEN_GAP;
                  end else begin
                     r_data <= r_data + DATA_WIDTH'(1);
                     r_idx  <= w_idx_nxt;
                     r_last <= (w_idx_nxt == (r_len - LEN_WIDTH'(1)));
                  end
               end
            end
            GEN_GAP: begin
               // a zero period still costs one gap cycle
               if (r_gap <= PERIOD_WIDTH'(1)) begin
                  r_gap   <= '0;
                  r_state <= GEN_IDLE;
               end else begin
                  r_gap <= r_gap - PERIOD_WIDTH'(1);
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_state <= GEN_IDLE;
            end
         endcase
      end
   end

   assign o_tvalid = r_valid;
   assign o_tdata  = r_data;
   assign o_tlast  = r_last;

endmodule

// File: rtl/aurora_stream_ctrl.sv
// Aurora user-interface stream controller: RX frame statistics and a
// frame-boundary-safe TX arbiter between user, loopback and generator sources.
module aurora_stream_ctrl
   import aurora_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int CNT_WIDTH    = 16,
   parameter int LEN_WIDTH    = 8,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    m_axis_aclk,
   input  logic                    m_axis_aresetn,
   input  logic                    rx_tvalid,
   input  logic [DATA_WIDTH-1:0]   rx_tdata,
   input  logic                    rx_tlast,
   input  logic                    lb_tvalid,
   input  logic [DATA_WIDTH-1:0]   lb_tdata,
   input  logic                    lb_tlast,
   output logic                    lb_tready,
   input  logic                    usr_tvalid,
   input  logic [DATA_WIDTH-1:0]   usr_tdata,
   input  logic                    usr_tlast,
   output logic                    usr_tready,
   output logic                    tx_tvalid,
   output logic [DATA_WIDTH-1:0]   tx_tdata,
   output logic                    tx_tlast,
   input  logic                    tx_tready,
   input  logic [1:0]              ctrl_mode,
   input  logic [LEN_WIDTH-1:0]    ctrl_gen_len,
   input  logic [PERIOD_WIDTH-1:0] ctrl_gen_period,
   input  logic [DATA_WIDTH-1:0]   ctrl_gen_base,
   output logic [CNT_WIDTH-1:0]    stat_rx_words,
   output logic                    stat_rx_words_rdy,
   output logic [CNT_WIDTH-1:0]    stat_rx_frames,
   output logic [CNT_WIDTH-1:0]    stat_tx_frames,
   output logic                    rx_last_pulse
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   mode_e                  r_active;
   logic                   r_frame_open;
   logic [CNT_WIDTH-1:0]   r_rx_words;
   logic [CNT_WIDTH-1:0]   r_rx_frames;
   logic [CNT_WIDTH-1:0]   r_tx_frames;
   logic                   r_rx_rdy;
   logic                   r_rx_first;
   logic                   r_rx_last_pulse;

   logic                   w_tx_hs;
   logic                   w_tx_close;
   logic                   w_open_nxt;
   logic                   w_gen_en;
   logic                   w_gen_tready;
   logic                   w_gen_tvalid;
   logic [DATA_WIDTH-1:0]  w_gen_tdata;
   logic                   w_gen_tlast;
   logic                   w_unused_rx_tdata;

   // RX data is only observed, never forwarded
   assign w_unused_rx_tdata = ^rx_tdata;

   assign w_tx_hs    = tx_tvalid & tx_tready;
   assign w_tx_close = w_tx_hs & tx_tlast;
   assign w_open_nxt = w_tx_close ? 1'b0 : (r_frame_open | w_tx_hs);
   assign w_gen_en   = (r_active == MODE_GEN);

   // Track open TX frame; source may only change when the next cycle starts between frames
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_frame_open <= 1'b0;
         r_active     <= MODE_OFF;
      end else begin
         r_frame_open <= w_open_nxt;
         if (!w_open_nxt) begin
            r_active <= mode_e'(ctrl_mode);
         end
      end
   end

   // Zero-latency TX mux; unselected sources see tready low
   always_comb begin
      tx_tvalid    = 1'b0;
      tx_tdata     = '0;
      tx_tlast     = 1'b0;
      usr_tready   = 1'b0;
      lb_tready    = 1'b0;
      w_gen_tready = 1'b0;
      case (r_active)
         MODE_USER: begin
            tx_tvalid  = usr_tvalid;
            tx_tdata   = usr_tdata;
            tx_tlast   = usr_tlast;
            usr_tready = tx_tready;
         end
         MODE_LOOP: begin
            tx_tvalid = lb_tvalid;
            tx_tdata  = lb_tdata;
            tx_tlast  = lb_tlast;
            lb_tready = tx_tready;
         end
         MODE_GEN: begin
            tx_tvalid    = w_gen_tvalid;
            tx_tdata     = w_gen_tdata;
            tx_tlast     = w_gen_tlast;
            w_gen_tready = tx_tready;
         end
         default: begin
            tx_tvalid = 1'b0;
         end
      endcase
   end

   axis_frame_gen #(
      .DATA_WIDTH   (DATA_WIDTH),
      .LEN_WIDTH    (LEN_WIDTH),
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_gen (
      .i_clk    (m_axis_aclk),
      .i_rst_n  (m_axis_aresetn),
      .i_en     (w_gen_en),
      .i_len    (ctrl_gen_len),
      .i_period (ctrl_gen_period),
      .i_base   (ctrl_gen_base),
      .i_tready (w_gen_tready),
      .o_tvalid (w_gen_tvalid),
      .o_tdata  (w_gen_tdata),
      .o_tlast  (w_gen_tlast)
   );

   // RX word/frame statistics and end-of-frame pulse, saturating counters
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_rx_words      <= '0;
         r_rx_frames     <= '0;
         r_rx_rdy        <= 1'b0;
         r_rx_first      <= 1'b1;
         r_rx_last_pulse <= 1'b0;
      end else begin
         r_rx_last_pulse <= rx_tvalid & rx_tlast;
         if (rx_tvalid) begin
            if (r_rx_first) begin
               r_rx_words <= CNT_ONE;
            end else if (r_rx_words != CNT_MAX) begin
               r_rx_words <= r_rx_words + CNT_ONE;
            end
            r_rx_first <= rx_tlast;
            r_rx_rdy   <= rx_tlast;
            if (rx_tlast && (r_rx_frames != CNT_MAX)) begin
               r_rx_frames <= r_rx_frames + CNT_ONE;
            end
         end
      end
   end

   // Completed TX frames from any source, saturating
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_tx_frames <= '0;
      end else if (w_tx_close && (r_tx_frames != CNT_MAX)) begin
         r_tx_frames <= r_tx_frames + CNT_ONE;
      end
   end

   assign stat_rx_words     = r_rx_words;
   assign stat_rx_words_rdy = r_rx_rdy & ~rx_tvalid;
   assign stat_rx_frames    = r_rx_frames;
   assign stat_tx_frames    = r_tx_frames;
   assign rx_last_pulse     = r_rx_last_pulse;

endmodule

// File: tb/tb_aurora_stream_ctrl.sv
// Directed bench for aurora_stream_ctrl: RX stats, generator timing and data,
// mode switching at frame boundaries, counter saturation and async reset.
module tb_aurora_stream_ctrl;

   logic        clk;
   logic        rst_n;
   logic        rx_tvalid, rx_tlast;
   logic [31:0] rx_tdata;
   logic        lb_tvalid, lb_tlast, lb_tready;
   logic [31:0] lb_tdata;
   logic        usr_tvalid, usr_tlast, usr_tready;
   logic [31:0] usr_tdata;
   logic        tx_tvalid, tx_tlast, tx_tready;
   logic [31:0] tx_tdata;
   logic [1:0]  ctrl_mode;
   logic [7:0]  ctrl_gen_len;
   logic [15:0] ctrl_gen_period;
   logic [31:0] ctrl_gen_base;
   logic [15:0] stat_rx_words, stat_rx_frames, stat_tx_frames;
   logic        stat_rx_words_rdy, rx_last_pulse;

   logic        c4_unused_lb_tready, c4_unused_usr_tready;
   logic        c4_unused_tx_tvalid, c4_unused_tx_tlast;
   logic [31:0] c4_unused_tx_tdata;
   logic [3:0]  c4_unused_rx_words, c4_rx_frames, c4_unused_tx_frames;
   logic        c4_unused_rdy, c4_unused_pulse;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [31:0] q_data[$];
   bit          q_last[$];
   int          q_cyc[$];

   aurora_stream_ctrl dut (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
      .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tlast(rx_tlast),
      .lb_tvalid(lb_tvalid), .lb_tdata(lb_tdata), .lb_tlast(lb_tlast), .lb_tready(lb_tready),
      .usr_tvalid(usr_tvalid), .usr_tdata(usr_tdata), .usr_tlast(usr_tlast), .usr_tready(usr_tready),
      .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
      .ctrl_mode(ctrl_mode), .ctrl_gen_len(ctrl_gen_len), .ctrl_gen_period(ctrl_gen_period),
      .ctrl_gen_base(ctrl_gen_base),
      .stat_rx_words(stat_rx_words), .stat_rx_words_rdy(stat_rx_words_rdy),
      .stat_rx_frames(stat_rx_frames), .stat_tx_frames(stat_tx_frames),
      .rx_last_pulse(rx_last_pulse)
   );

   aurora_stream_ctrl #(.CNT_WIDTH(4)) dut_c4 (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
      .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tlast(rx_tlast),
      .lb_tvalid(lb_tvalid), .lb_tdata(lb_tdata), .lb_tlast(lb_tlast), .lb_tready(c4_unused_lb_tready),
      .usr_tvalid(usr_tvalid), .usr_tdata(usr_tdata), .usr_tlast(usr_tlast), .usr_tready(c4_unused_usr_tready),
      .tx_tvalid(c4_unused_tx_tvalid), .tx_tdata(c4_unused_tx_tdata), .tx_tlast(c4_unused_tx_tlast),
      .tx_tready(tx_tready),
      .ctrl_mode(ctrl_mode), .ctrl_gen_len(ctrl_gen_len), .ctrl_gen_period(ctrl_gen_period),
      .ctrl_gen_base(ctrl_gen_base),
      .stat_rx_words(c4_unused_rx_words), .stat_rx_words_rdy(c4_unused_rdy),
      .stat_rx_frames(c4_rx_frames), .stat_tx_frames(c4_unused_tx_frames),
      .rx_last_pulse(c4_unused_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // record every TX handshake mid-cycle
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (tx_tvalid && tx_tready) begin
         q_data.push_back(tx_tdata);
         q_last.push_back(tx_tlast);
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_beat(input bit last);
      rx_tvalid = 1'b1;
      rx_tlast  = last;
      rx_tdata  = $urandom;
      step();
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      #1;
   endtask

   task automatic wait_beats(input int n, input int limit);
      int k;
      k = 0;
      while (q_data.size() < n && k < limit) begin
         step();
         k++;
      end
      if (q_data.size() < n) check("beat_timeout", q_data.size(), n);
   endtask

   task automatic clear_q();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   initial begin
      int have_prev;
      logic [31:0] prev_data;
      int k;

      rst_n = 1'b0;
      rx_tvalid = 0; rx_tlast = 0; rx_tdata = '0;
      lb_tvalid = 0; lb_tlast = 0; lb_tdata = '0;
      usr_tvalid = 0; usr_tlast = 0; usr_tdata = '0;
      tx_tready = 0;
      ctrl_mode = 2'b11;
      ctrl_gen_len = '0; ctrl_gen_period = '0; ctrl_gen_base = '0;

      // reset state
      #12;
      check("rst_tx_tvalid", tx_tvalid, 0);
      check("rst_usr_tready", usr_tready, 0);
      check("rst_lb_tready", lb_tready, 0);
      check("rst_rx_words", stat_rx_words, 0);
      check("rst_rx_frames", stat_rx_frames, 0);
      check("rst_tx_frames", stat_tx_frames, 0);
      check("rst_rdy", stat_rx_words_rdy, 0);
      check("rst_pulse", rx_last_pulse, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      step();

      // RX: 5-beat frame with gaps
      for (int b = 0; b < 4; b++) begin
         rx_beat(0);
         step();
      end
      check("rx_words_mid", stat_rx_words, 4);
      check("rx_rdy_mid", stat_rx_words_rdy, 0);
      rx_beat(1);
      check("rx_pulse_hi", rx_last_pulse, 1);
      check("rx_words5", stat_rx_words, 5);
      check("rx_rdy5", stat_rx_words_rdy, 1);
      check("rx_frames1", stat_rx_frames, 1);
      step();
      check("rx_pulse_lo", rx_last_pulse, 0);
      check("rx_rdy_hold", stat_rx_words_rdy, 1);

      // rdy drops combinationally when the next frame starts
      rx_tvalid = 1'b1; rx_tlast = 1'b1; #1;
      check("rx_rdy_drop", stat_rx_words_rdy, 0);
      step();
      rx_tvalid = 1'b0; rx_tlast = 1'b0; #1;
      check("rx_words1", stat_rx_words, 1);
      check("rx_rdy1", stat_rx_words_rdy, 1);
      check("rx_frames2", stat_rx_frames, 2);
      for (int f = 0; f < 18; f++) rx_beat(1);
      check("rx_frames20", stat_rx_frames, 20);
      check("rx_frames_sat4", c4_rx_frames, 15);

      // generator len=2 base=5 period=255
      clear_q();
      ctrl_gen_len = 8'd2; ctrl_gen_base = 32'd5; ctrl_gen_period = 16'd255;
      tx_tready = 1'b1;
      ctrl_mode = 2'b10;
      wait_beats(4, 400);
      if (q_data.size() >= 4) begin
         check("gen_d0", q_data[0], 5);
         check("gen_l0", q_last[0], 0);
         check("gen_d1", q_data[1], 6);
         check("gen_l1", q_last[1], 1);
         check("gen_b2b", q_cyc[1] - q_cyc[0], 1);
         check("gen_gap", q_cyc[2] - q_cyc[1] - 1, 256);
         check("gen_d2", q_data[2], 5);
         check("gen_d3", q_data[3], 6);
         check("gen_l3", q_last[3], 1);
      end
      check("gen_tx_frames", stat_tx_frames, 2);
      ctrl_mode = 2'b11;
      repeat (300) step();

      // generator len=3 with tready toggling
      clear_q();
      ctrl_gen_len = 8'd3; ctrl_gen_base = 32'h100; ctrl_gen_period = 16'd0;
      ctrl_mode = 2'b10;
      have_prev = 0;
      prev_data = '0;
      k = 0;
      while (q_data.size() < 3 && k < 40) begin
         tx_tready = ~tx_tready;
         #1;
         if (have_prev != 0) check("gen_hold", tx_tdata, prev_data);
         have_prev = (tx_tvalid && !tx_tready) ? 1 : 0;
         prev_data = tx_tdata;
         step();
         k++;
      end
      ctrl_mode = 2'b11;
      if (q_data.size() < 3) check("toggle_timeout", q_data.size(), 3);
      else begin
         check("tog_d0", q_data[0], 32'h100);
         check("tog_d1", q_data[1], 32'h101);
         check("tog_d2", q_data[2], 32'h102);
         check("tog_last", {q_last[0], q_last[1], q_last[2]}, 3'b001);
      end
      repeat (5) step();

      // loopback -> user switch on beat 2 of a 4-word loopback frame
      tx_tready = 1'b1;
      usr_tvalid = 1'b1; usr_tdata = 32'hA5A5_0001; usr_tlast = 1'b1;
      ctrl_mode = 2'b01;
      step();
      check("lb_sel_ready", lb_tready, 1);
      check("lb_usr_ready0", usr_tready, 0);
      lb_tvalid = 1'b1; lb_tdata = 32'hB0; lb_tlast = 1'b0;
      step();
      lb_tdata = 32'hB1;
      ctrl_mode = 2'b00;
      step();
      lb_tdata = 32'hB2; #1;
      check("sw_usr_ready_b2", usr_tready, 0);
      check("sw_lb_data_b2", tx_tdata, 32'hB2);
      step();
      lb_tdata = 32'hB3; lb_tlast = 1'b1; #1;
      check("sw_usr_ready_b3", usr_tready, 0);
      check("sw_lb_last", tx_tlast, 1);
      step();
      lb_tvalid = 1'b0; lb_tlast = 1'b0; #1;
      check("sw_usr_ready_on", usr_tready, 1);
      check("sw_lb_ready_off", lb_tready, 0);
      check("sw_usr_data", tx_tdata, 32'hA5A5_0001);
      check("sw_tx_frames", stat_tx_frames, 4);
      usr_tvalid = 1'b0; usr_tlast = 1'b0;
      step();

      // generator data wraps modulo 2^32
      clear_q();
      ctrl_gen_len = 8'd2; ctrl_gen_base = 32'hFFFF_FFFF; ctrl_gen_period = 16'd0;
      ctrl_mode = 2'b10;
      wait_beats(2, 20);
      tx_tready = 1'b0;
      if (q_data.size() >= 2) begin
         check("wrap_d0", q_data[0], 32'hFFFF_FFFF);
         check("wrap_d1", q_data[1], 32'h0);
         check("wrap_l1", q_last[1], 1);
      end

      // async reset mid SEND, then restart at base
      k = 0;
      while (!tx_tvalid && k < 10) begin
         step();
         k++;
      end
      tx_tready = 1'b1;
      step();
      tx_tready = 1'b0; #1;
      check("mid_send_valid", tx_tvalid, 1);
      check("mid_send_data", tx_tdata, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tx_valid", tx_tvalid, 0);
      check("arst_tx_frames", stat_tx_frames, 0);
      check("arst_rx_frames", stat_rx_frames, 0);
      check("arst_rx_words", stat_rx_words, 0);
      clear_q();
      ctrl_gen_base = 32'h40;
      tx_tready = 1'b1;
      @(posedge clk); #3;
      rst_n = 1'b1;
      wait_beats(2, 20);
      if (q_data.size() >= 2) begin
         check("rst_gen_d0", q_data[0], 32'h40);
         check("rst_gen_d1", q_data[1], 32'h41);
         check("rst_gen_l1", q_last[1], 1);
      end
      check("rst_gen_frames", stat_tx_frames, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
